// File: rtl/mem_arbiter.sv
// mem_arbiter: three-client memory request arbiter with periodic refresh.
// Priority is pending refresh, then client 0 (display read), then clients 1/2
// (MC read / framestore write) in round-robin. Winners are registered into the
// memory-controller request FIFO one cycle after the grant; reads also push a
// client tag into the response-routing FIFO.
module mem_arbiter #(
  parameter int unsigned REFRESH_CYCLES = 1560
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        disp_rd_valid,
  input  logic [21:0] disp_rd_addr,
  output logic        disp_rd_ack,
  input  logic        mc_rd_valid,
  input  logic [21:0] mc_rd_addr,
  output logic        mc_rd_ack,
  input  logic        fs_wr_valid,
  input  logic [21:0] fs_wr_addr,
  input  logic [63:0] fs_wr_dta,
  output logic        fs_wr_ack,
  output logic [1:0]  mem_req_wr_cmd,
  output logic [21:0] mem_req_wr_addr,
  output logic [63:0] mem_req_wr_dta,
  output logic        mem_req_wr_en,
  input  logic        mem_req_wr_almost_full,
  output logic [1:0]  mem_tag_wr_dta,
  output logic        mem_tag_wr_en,
  output logic        refresh_overrun
);

  localparam logic [1:0]  CMD_NOOP    = 2'd0;
  localparam logic [1:0]  CMD_REFRESH = 2'd1;
  localparam logic [1:0]  CMD_READ    = 2'd2;
  localparam logic [1:0]  CMD_WRITE   = 2'd3;
  localparam logic [15:0] RELOAD      = 16'(REFRESH_CYCLES - 1);

  logic [15:0] r_cnt;
  logic        r_pending;
  logic        r_overrun;
  logic        r_fav2;     // 0: client 1 favoured, 1: client 2 favoured
  logic [1:0]  r_cmd;
  logic [21:0] r_addr;
  logic [63:0] r_dta;
  logic        r_en;
  logic [1:0]  r_tag;
  logic        r_tag_en;

  logic w_expire;
  logic w_open;
  logic w_sel_ref;
  logic w_ack0;
  logic w_ack1;
  logic w_ack2;

  // Nothing is selected in reset or while the request FIFO is nearly full.
  assign w_open    = rst & ~mem_req_wr_almost_full;
  assign w_expire  = (r_cnt == 16'd0);
  assign w_sel_ref = w_open & r_pending;
  assign w_ack0    = w_open & ~r_pending & disp_rd_valid;
  assign w_ack1    = w_open & ~r_pending & ~disp_rd_valid & mc_rd_valid &
                     (~fs_wr_valid | ~r_fav2);
  assign w_ack2    = w_open & ~r_pending & ~disp_rd_valid & fs_wr_valid &
                     (~mc_rd_valid | r_fav2);

  assign disp_rd_ack     = w_ack0;
  assign mc_rd_ack       = w_ack1;
  assign fs_wr_ack       = w_ack2;
  assign mem_req_wr_cmd  = r_cmd;
  assign mem_req_wr_addr = r_addr;
  assign mem_req_wr_dta  = r_dta;
  assign mem_req_wr_en   = r_en;
  assign mem_tag_wr_dta  = r_tag;
  assign mem_tag_wr_en   = r_tag_en;
  assign refresh_overrun = r_overrun;

  // Free-running refresh interval counter; keeps counting through stalls.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= RELOAD;
    end else if (w_expire) begin
      r_cnt <= RELOAD;
    end else begin
      r_cnt <= r_cnt - 16'd1;
    end
  end

  // Single pending refresh; an expiry that finds one still waiting is an overrun.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pending <= 1'b0;
      r_overrun <= 1'b0;
    end else if (w_expire) begin
      r_pending <= 1'b1;
      if (r_pending && !w_sel_ref) r_overrun <= 1'b1;
    end else if (w_sel_ref) begin
      r_pending <= 1'b0;
    end
  end

  // Round-robin pointer moves only on client 1/2 grants.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_fav2 <= 1'b0;
    end else if (w_ack1) begin
      r_fav2 <= 1'b1;
    end else if (w_ack2) begin
      r_fav2 <= 1'b0;
    end
  end

  // Register the winner into the request/tag FIFO push ports; hold fields when idle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cmd    <= CMD_NOOP;
      r_addr   <= 22'h0;
      r_dta    <= 64'h0;
      r_en     <= 1'b0;
      r_tag    <= 2'd0;
      r_tag_en <= 1'b0;
    end else begin
      r_en     <= w_sel_ref | w_ack0 | w_ack1 | w_ack2;
      r_tag_en <= w_ack0 | w_ack1;
      if (w_sel_ref) begin
        r_cmd  <= CMD_REFRESH;
        r_addr <= 22'h0;
        r_dta  <= 64'h0;
      end else if (w_ack0) begin
        r_cmd  <= CMD_READ;
        r_addr <= disp_rd_addr;
        r_dta  <= 64'h0;
        r_tag  <= 2'd0;
      end else if (w_ack1) begin
        r_cmd  <= CMD_READ;
        r_addr <= mc_rd_addr;
        r_dta  <= 64'h0;
        r_tag  <= 2'd1;
      end else if (w_ack2) begin
        r_cmd  <= CMD_WRITE;
        r_addr <= fs_wr_addr;
        r_dta  <= fs_wr_dta;
      end
    end
  end

endmodule
